ca_correlator: RTL and testbench
================================

# ca_correlator

Early/prompt/late code correlator that sits directly downstream of the C/A code generator. Each clock it takes one chip and its chip index from the generator, plus one I/Q baseband sample. It multiplies the sample by three one-chip-spaced replicas and accumulates six sums over one 1023-chip code epoch. At each epoch boundary it dumps the sums into a held output register with a valid/ready handshake for the tracking-loop logic.

## Interface
- SAMPLE_W, 3: signed I/Q sample width (two's complement).
- ACC_W, SAMPLE_W+10: accumulator/output width. Must be ≥ SAMPLE_W+10 so a full epoch cannot overflow.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low (0 = reset), sampled on the clk rising edge.
- ca_bit  in  1  current chip from the code generator.
- code_shift  in  10  chip index of ca_bit, counting 0..1022 and wrapping to 0.
- sample_valid  in  1  i_sample/q_sample are valid this cycle.
- i_sample, q_sample  in  SAMPLE_W  signed baseband samples.
- dump_ie, dump_qe, dump_ip, dump_qp, dump_il, dump_ql  out  ACC_W  signed epoch sums (early/prompt/late × I/Q).
- dump_count  out  11  number of valid samples in the dumped epoch (0..1023).
- dump_valid  out  1  output register holds an unconsumed dump.
- dump_ready  in  1  consumer accepts the dump when dump_valid && dump_ready.
- overrun  out  1  sticky; a dump was dropped because the output register was still full.

## Operation
- Delay line: ca_d1 <= ca_bit, ca_d2 <= ca_d1.
  - Early = ca_bit, prompt = ca_d1, late = ca_d2; the samples of cycle t are paired with these three.
- Chip mapping: bit 0 → +1, bit 1 → −1.
  - Product is the sample or its two's-complement negation, sign-extended to ACC_W before negation; −2^(SAMPLE_W−1) negates without wrap.
- sample_valid=0: the product is 0 and the count does not increment. The delay line still advances.
- Epoch boundary: a cycle with code_shift==1 (prompt chip index 0). The epoch covers code_shift 1..1022,0, i.e. 1023 cycles.
- On a boundary:
  - All six accumulators load this cycle's product; they are not cleared to 0.
  - acc_count loads sample_valid.
  - The previous totals are offered to the output register.
- Other cycles: acc += product; acc_count += sample_valid.
- armed flag:
  - Cleared by reset, set at the first boundary.
  - A boundary with armed=0 discards the partial sums and does not dump.
- Output register states:
  - EMPTY: dump_valid=0.
  - FULL: dump_valid=1.
  - EMPTY → FULL on an armed boundary.
  - FULL → EMPTY on handshake with no boundary.
  - FULL stays FULL on a boundary coinciding with handshake; the new dump loads.
  - FULL with a boundary and no handshake: the new dump is dropped, the held dump is unchanged, and overrun is set.
- Outputs are stable while dump_valid=1 and not accepted.
- Reset values: ca_d1=ca_d2=0, accumulators=0, acc_count=0, armed=0, all dump_* = 0, dump_valid=0, overrun=0.
- Reset mid-epoch aborts the epoch and discards its sums. The first boundary after reset only arms.

## Timing
- Boundary sampled at edge t → new dump_* and dump_valid=1 visible after edge t. Latency is 1 cycle from the boundary cycle.
- Handshake completes at the edge where dump_valid && dump_ready. dump_valid drops after that edge unless the same edge loads a new dump.
- dump_ready is not required to be combinationally related to dump_valid; there is no comb path from dump_ready to any output.
- overrun is set at the edge of the dropping boundary and cleared only by reset.
- Sustained rate: one dump per 1023 cycles. The consumer has 1022 cycles of slack.

## Structure
- Package ca_pkg:
  - CA_LEN=1023.
  - EPOCH_IDX=10'd1.
  - Count width constant 11.
  - Function chip_sign(bit, sample, ACC_W) returning the signed product.
- Sub-module ca_accum_lane:
  - One signed accumulator with inputs code bit, sample, valid, load (boundary).
  - Outputs the running sum and the epoch total.
  - Instantiated six times.
- Top level holds the delay line, counter, armed flag, output register/handshake and overrun.

## Test plan
- Reset: hold reset=0 for 3 cycles with random inputs → every output 0, dump_valid=0, overrun=0. Release; the first boundary produces no dump.
- Constant: ca_bit=0, i_sample=+1, q_sample=−2, sample_valid=1, code_shift counting. At the second boundary: dump_ip=dump_ie=dump_il=1023, dump_qp=−2046, dump_count=1023, dump_valid=1.
- Alternating code: ca_bit toggles every cycle, i_sample=+1 when ca_d1=0 else −1. Result: dump_ip=+1023, dump_ie=dump_il=−1023.
- Gaps: as in the constant test, with sample_valid=0 for 100 cycles mid-epoch → dump_ip=923, dump_count=923.
- Backpressure: dump_ready=0 across two armed boundaries. The first dump is held unchanged, the second is dropped, overrun=1. Then dump_ready=1 for 1 cycle → dump_valid=0 next cycle; overrun stays 1.
- Reset mid-epoch at code_shift=500 → outputs cleared next edge. The next boundary gives no dump; the following boundary gives a full 1023-sample dump.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared constants, output-register states and the chip-sign helper for the C/A correlator.
package ca_pkg;

    localparam int unsigned CA_LEN    = 1023;
    localparam int unsigned CS_W      = 10;
    localparam int unsigned CNT_W     = 11;
    localparam int unsigned NUM_TAPS  = 3;
    localparam int unsigned MAX_ACC_W = 32;

    localparam int unsigned TAP_EARLY  = 0;
    localparam int unsigned TAP_PROMPT = 1;
    localparam int unsigned TAP_LATE   = 2;

    // Prompt chip index 0 lines up with this generator index.
    localparam logic [CS_W-1:0] EPOCH_IDX = 10'd1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } out_state_e;

    // Chip 0 -> +sample, chip 1 -> -sample; sample arrives already sign-extended
    // to the wide type, so negating the most negative input cannot wrap.
    function automatic logic signed [MAX_ACC_W-1:0] chip_sign(
        input logic                        chip,
        input logic signed [MAX_ACC_W-1:0] sample_ext
    );
        return chip ? -sample_ext : sample_ext;
    endfunction

endpackage

// File: rtl/ca_accum_lane.sv
// One signed correlation accumulator: sums chip-signed samples, restarting on each epoch boundary.
module ca_accum_lane
    import ca_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 3,
    parameter int unsigned ACC_W    = SAMPLE_W + 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       code_bit_i,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic                       valid_i,
    input  logic                       load_i,
    output logic signed [ACC_W-1:0]    sum_o
);

    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    // Product of this cycle; a boundary starts the new epoch with it instead of adding.
    always_comb begin
        prod = '0;
        if (valid_i) begin
            prod = ACC_W'(chip_sign(code_bit_i, MAX_ACC_W'(sample_i)));
        end
        acc_d = load_i ? prod : (acc_q + prod);
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // At a boundary cycle this holds the complete total of the epoch just ended.
    assign sum_o = acc_q;

endmodule

// File: rtl/ca_correlator.sv
// Early/prompt/late C/A code correlator with per-epoch dump register and valid/ready handshake.
module ca_correlator
    import ca_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 3,
    parameter int unsigned ACC_W    = SAMPLE_W + 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ca_bit,
    input  logic [CS_W-1:0]            code_shift,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] i_sample,
    input  logic signed [SAMPLE_W-1:0] q_sample,
    output logic signed [ACC_W-1:0]    dump_ie,
    output logic signed [ACC_W-1:0]    dump_qe,
    output logic signed [ACC_W-1:0]    dump_ip,
    output logic signed [ACC_W-1:0]    dump_qp,
    output logic signed [ACC_W-1:0]    dump_il,
    output logic signed [ACC_W-1:0]    dump_ql,
    output logic [CNT_W-1:0]           dump_count,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic                       overrun
);

    // A full epoch of extreme samples must fit in the accumulator and the helper's width.
    if ((ACC_W < SAMPLE_W + $clog2(CA_LEN + 1)) || (ACC_W > MAX_ACC_W)) begin : g_acc_w_check
        $error("ca_correlator: ACC_W out of range");
    end

    logic                    ca_d1_q, ca_d2_q;
    logic                    armed_q, armed_d;
    logic                    overrun_q, overrun_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    out_state_e              state_q, state_d;
    logic                    boundary;
    logic                    offer;
    logic                    load_dump;
    logic [NUM_TAPS-1:0]     tap_chip;
    logic signed [ACC_W-1:0] sum_i [NUM_TAPS];
    logic signed [ACC_W-1:0] sum_q [NUM_TAPS];
    logic signed [ACC_W-1:0] dump_i_q [NUM_TAPS];
    logic signed [ACC_W-1:0] dump_q_q [NUM_TAPS];
    logic [CNT_W-1:0]        dump_cnt_q;

    assign boundary = (code_shift == EPOCH_IDX);
    assign offer    = boundary && armed_q;
    assign tap_chip = {ca_d2_q, ca_d1_q, ca_bit};

    // Six lanes: early/prompt/late replica against I and Q.
    for (genvar t = 0; t < NUM_TAPS; t++) begin : g_tap
        ca_accum_lane #(
            .SAMPLE_W (SAMPLE_W),
            .ACC_W    (ACC_W)
        ) u_lane_i (
            .clk        (clk),
            .reset      (reset),
            .code_bit_i (tap_chip[t]),
            .sample_i   (i_sample),
            .valid_i    (sample_valid),
            .load_i     (boundary),
            .sum_o      (sum_i[t])
        );

        ca_accum_lane #(
            .SAMPLE_W (SAMPLE_W),
            .ACC_W    (ACC_W)
        ) u_lane_q (
            .clk        (clk),
            .reset      (reset),
            .code_bit_i (tap_chip[t]),
            .sample_i   (q_sample),
            .valid_i    (sample_valid),
            .load_i     (boundary),
            .sum_o      (sum_q[t])
        );
    end

    // Valid-sample counter and arming; the first boundary after reset only arms.
    always_comb begin
        cnt_d   = boundary ? CNT_W'(sample_valid) : (cnt_q + CNT_W'(sample_valid));
        armed_d = armed_q | boundary;
    end

    // Output register next state: load, hold, drain or drop-with-overrun.
    always_comb begin
        state_d   = state_q;
        load_dump = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            S_EMPTY: begin
                if (offer) begin
                    load_dump = 1'b1;
                    state_d   = S_FULL;
                end
            end
            S_FULL: begin
                if (offer) begin
                    if (dump_ready) begin
                        load_dump = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (dump_ready) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Control state: delay line, counter, arming, handshake state and sticky overrun.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ca_d1_q   <= 1'b0;
            ca_d2_q   <= 1'b0;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            overrun_q <= 1'b0;
            state_q   <= S_EMPTY;
        end else begin
            ca_d1_q   <= ca_bit;
            ca_d2_q   <= ca_d1_q;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
        end
    end

    // Held dump payload; only changes when a new epoch is accepted into the register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                dump_i_q[k] <= '0;
                dump_q_q[k] <= '0;
            end
            dump_cnt_q <= '0;
        end else if (load_dump) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                dump_i_q[k] <= sum_i[k];
                dump_q_q[k] <= sum_q[k];
            end
            dump_cnt_q <= cnt_q;
        end
    end

    assign dump_ie    = dump_i_q[TAP_EARLY];
    assign dump_qe    = dump_q_q[TAP_EARLY];
    assign dump_ip    = dump_i_q[TAP_PROMPT];
    assign dump_qp    = dump_q_q[TAP_PROMPT];
    assign dump_il    = dump_i_q[TAP_LATE];
    assign dump_ql    = dump_q_q[TAP_LATE];
    assign dump_count = dump_cnt_q;
    assign dump_valid = (state_q == S_FULL);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ca_correlator.sv
// Scoreboard bench for ca_correlator: directed epochs with hand-computed dump values.
`timescale 1ns/1ps
module tb_ca_correlator;

    localparam int SAMPLE_W = 3;
    localparam int ACC_W    = SAMPLE_W + 10;
    localparam int M_CONST  = 0;
    localparam int M_ALT    = 1;

    typedef struct {
        int ie; int qe; int ip; int qp; int il; int ql; int cnt;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       ca_bit;
    logic [9:0]                 code_shift;
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] i_sample;
    logic signed [SAMPLE_W-1:0] q_sample;
    logic signed [ACC_W-1:0]    dump_ie, dump_qe, dump_ip, dump_qp, dump_il, dump_ql;
    logic [10:0]                dump_count;
    logic                       dump_valid;
    logic                       dump_ready;
    logic                       overrun;

    int   tests;
    int   fails;
    int   cs;
    logic prev_bit;
    exp_t exp_q[$];
    exp_t e_const, e_alt, e_gap;

    ca_correlator #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .ca_bit       (ca_bit),
        .code_shift   (code_shift),
        .sample_valid (sample_valid),
        .i_sample     (i_sample),
        .q_sample     (q_sample),
        .dump_ie      (dump_ie),
        .dump_qe      (dump_qe),
        .dump_ip      (dump_ip),
        .dump_qp      (dump_qp),
        .dump_il      (dump_il),
        .dump_ql      (dump_ql),
        .dump_count   (dump_count),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int ie, input int qe, input int ip, input int qp,
                                input int il, input int ql, input int cnt);
        exp_t e;
        e.ie = ie; e.qe = qe; e.ip = ip; e.qp = qp; e.il = il; e.ql = ql; e.cnt = cnt;
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One generator cycle per iteration; samples in [gap_lo, gap_hi) chip indices are invalid.
    task automatic drive_cycles(input int n, input int mode, input int gap_lo, input int gap_hi);
        for (int k = 0; k < n; k++) begin
            code_shift   = 10'(cs);
            sample_valid = !(cs >= gap_lo && cs < gap_hi);
            if (mode == M_ALT) begin
                ca_bit   = ~prev_bit;
                i_sample = prev_bit ? SAMPLE_W'(-1) : SAMPLE_W'(1);
                q_sample = prev_bit ? SAMPLE_W'(1) : SAMPLE_W'(-1);
            end else begin
                ca_bit   = 1'b0;
                i_sample = SAMPLE_W'(1);
                q_sample = SAMPLE_W'(-2);
            end
            @(posedge clk); #1;
            prev_bit = ca_bit;
            cs = (cs == 1022) ? 0 : cs + 1;
        end
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b0;
        for (int k = 0; k < n; k++) begin
            ca_bit       = 1'($urandom);
            code_shift   = 10'($urandom_range(1022, 0));
            sample_valid = 1'($urandom);
            i_sample     = SAMPLE_W'($urandom);
            q_sample     = SAMPLE_W'($urandom);
            @(posedge clk); #1;
        end
        reset    = 1'b1;
        prev_bit = ca_bit;
    endtask

    // Starting just after reset at chip 2: arm at the first boundary, dump at the second.
    task automatic arm_then_epoch(input int mode, input int gap_lo, input int gap_hi, input exp_t e);
        cs = 2;
        exp_q.push_back(e);
        drive_cycles(1022, mode, gap_lo, gap_hi);
        drive_cycles(1, mode, gap_lo, gap_hi);
        @(negedge clk);
        check("arm_boundary_no_dump", dump_valid, 0);
        drive_cycles(1023, mode, gap_lo, gap_hi);
        drive_cycles(2, mode, gap_lo, gap_hi);
    endtask

    // Monitor: every accepted dump is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && dump_valid && dump_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_dump: dump_ip=%0d dump_count=%0d, expected no dump", dump_ip, dump_count);
                end else begin
                    e = exp_q.pop_front();
                    check("dump_ie", dump_ie, e.ie);
                    check("dump_qe", dump_qe, e.qe);
                    check("dump_ip", dump_ip, e.ip);
                    check("dump_qp", dump_qp, e.qp);
                    check("dump_il", dump_il, e.il);
                    check("dump_ql", dump_ql, e.ql);
                    check("dump_count", dump_count, e.cnt);
                end
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        cs = 0;
        prev_bit = 1'b0;
        reset = 1'b0;
        dump_ready = 1'b1;
        ca_bit = 1'b0;
        code_shift = '0;
        sample_valid = 1'b0;
        i_sample = '0;
        q_sample = '0;
        e_const = mk(1023, -2046, 1023, -2046, 1023, -2046, 1023);
        e_alt   = mk(-1023, 1023, 1023, -1023, -1023, 1023, 1023);
        e_gap   = mk(923, -1846, 923, -1846, 923, -1846, 923);

        // Reset values after three reset cycles with random inputs.
        apply_reset(3);
        @(negedge clk);
        check("rst_dump_ie", dump_ie, 0);
        check("rst_dump_qe", dump_qe, 0);
        check("rst_dump_ip", dump_ip, 0);
        check("rst_dump_qp", dump_qp, 0);
        check("rst_dump_il", dump_il, 0);
        check("rst_dump_ql", dump_ql, 0);
        check("rst_dump_count", dump_count, 0);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_overrun", overrun, 0);

        // Constant code and samples.
        arm_then_epoch(M_CONST, -1, -1, e_const);

        // Alternating code with prompt-matched I sample.
        apply_reset(3);
        arm_then_epoch(M_ALT, -1, -1, e_alt);

        // 100-sample gap in the middle of the epoch.
        apply_reset(3);
        arm_then_epoch(M_CONST, 300, 400, e_gap);

        // Backpressure across two armed boundaries.
        apply_reset(3);
        dump_ready = 1'b0;
        cs = 2;
        exp_q.push_back(e_const);
        drive_cycles(1023, M_CONST, -1, -1);
        drive_cycles(1023, M_CONST, -1, -1);
        @(negedge clk);
        check("bp_first_valid", dump_valid, 1);
        check("bp_first_ip", dump_ip, 1023);
        check("bp_first_overrun", overrun, 0);
        drive_cycles(1023, M_CONST, 300, 400);
        @(negedge clk);
        check("bp_drop_overrun", overrun, 1);
        check("bp_drop_valid", dump_valid, 1);
        check("bp_held_ip", dump_ip, 1023);
        check("bp_held_count", dump_count, 1023);
        drive_cycles(3, M_CONST, -1, -1);
        dump_ready = 1'b1;
        drive_cycles(1, M_CONST, -1, -1);
        dump_ready = 1'b0;
        @(negedge clk);
        check("bp_drain_valid", dump_valid, 0);
        check("bp_overrun_sticky", overrun, 1);

        // Reset in the middle of an epoch.
        dump_ready = 1'b1;
        apply_reset(3);
        @(negedge clk);
        check("mid_overrun_cleared", overrun, 0);
        arm_then_epoch(M_CONST, -1, -1, e_const);
        drive_cycles(496, M_CONST, -1, -1);
        check("mid_reset_at_500", cs, 500);
        reset = 1'b0;
        drive_cycles(1, M_CONST, -1, -1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_dump_ip", dump_ip, 0);
        check("mid_rst_dump_qp", dump_qp, 0);
        check("mid_rst_dump_count", dump_count, 0);
        check("mid_rst_dump_valid", dump_valid, 0);
        drive_cycles(523, M_CONST, -1, -1);
        drive_cycles(1, M_CONST, -1, -1);
        @(negedge clk);
        check("mid_first_boundary_no_dump", dump_valid, 0);
        exp_q.push_back(e_const);
        drive_cycles(1023, M_CONST, -1, -1);
        drive_cycles(2, M_CONST, -1, -1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
